// File: rtl/mram_burst_seq_if.sv
// mram_burst_seq_if: request, address-beat handshake and status signals of the MRAM burst sequencer
//   master: the sequencer side, which takes requests and drives the address beats and status
//   slave : the environment side, which issues requests and consumes the address beats
interface mram_burst_seq_if #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 8
);
  logic              start;
  logic              mode_sel;
  logic              burst_type;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  burst_len;
  logic              abort;
  logic [ADDR_W-1:0] addr_out;
  logic              addr_valid;
  logic              addr_ready;
  logic              last;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [LEN_W-1:0]  beats_left;
  modport master (
    input  start, mode_sel, burst_type, start_addr, burst_len, abort, addr_ready,
    output addr_out, addr_valid, last, busy, done, aborted, beats_left
  );
  modport slave (
    output start, mode_sel, burst_type, start_addr, burst_len, abort, addr_ready,
    input  addr_out, addr_valid, last, busy, done, aborted, beats_left
  );
endinterface

// File: rtl/mram_burst_seq.sv
// mram_burst_seq: issues one address per beat (single, INCR or WRAP burst) over a valid/ready handshake
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : request inputs, addr_out/addr_valid/addr_ready beat handshake, last/busy/done/aborted/beats_left status
module mram_burst_seq #(
  parameter int ADDR_W    = 16,
  parameter int LEN_W     = 8,
  parameter int WRAP_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  mram_burst_seq_if.master     bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  state_t             r_state, w_state;
  logic [ADDR_W-1:0]  r_addr, w_addr, w_incr, w_wrapped;
  logic [LEN_W-1:0]   r_left, w_left, w_len_eff;
  logic               r_valid, w_valid, r_last, w_last, r_busy, w_busy;
  logic               r_done, w_done, r_aborted, w_aborted, r_wrap, w_wrap, w_acc;
  assign w_len_eff = (bus.mode_sel && bus.burst_len != '0) ? bus.burst_len : LEN_W'(1);
  assign w_acc     = r_valid & bus.addr_ready;
  assign w_incr    = r_addr + ADDR_W'(1);
  // WRAP keeps the upper bits and cycles only the low WRAP_LOG2 bits
  assign w_wrapped = {r_addr[ADDR_W-1:WRAP_LOG2], WRAP_LOG2'(r_addr[WRAP_LOG2-1:0] + WRAP_LOG2'(1))};
  always_comb begin
    w_state   = r_state;
    w_addr    = r_addr;
    w_left    = r_left;
    w_valid   = r_valid;
    w_last    = r_last;
    w_busy    = r_busy;
    w_wrap    = r_wrap;
    w_done    = 1'b0;
    w_aborted = 1'b0;
    case (r_state)
      IDLE: if (bus.start) begin
        w_state = ISSUE;
        w_addr  = bus.start_addr;
        w_left  = w_len_eff;
        w_valid = 1'b1;
        w_last  = w_len_eff == LEN_W'(1);
        w_busy  = 1'b1;
        w_wrap  = bus.mode_sel & bus.burst_type;
      end
      ISSUE: if (bus.abort) begin
        w_state   = IDLE;
        w_valid   = 1'b0;
        w_last    = 1'b0;
        w_busy    = 1'b0;
        w_left    = '0;
        w_aborted = 1'b1;
      end else if (w_acc) begin
        w_state = r_last ? DONE : ISSUE;
        w_valid = !r_last;
        w_done  = r_last;
        w_left  = r_last ? '0 : r_left - LEN_W'(1);
        w_last  = !r_last && r_left == LEN_W'(2);
        w_addr  = r_last ? r_addr : (r_wrap ? w_wrapped : w_incr);
      end
      default: begin
        w_state = IDLE;
        w_busy  = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_left    <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_addr    <= w_addr;
      r_left    <= w_left;
      r_valid   <= w_valid;
      r_last    <= w_last;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_aborted <= w_aborted;
      r_wrap    <= w_wrap;
    end
  end
  assign bus.addr_out   = r_addr;
  assign bus.addr_valid = r_valid;
  assign bus.last       = r_last;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.aborted    = r_aborted;
  assign bus.beats_left = r_left;
endmodule

// File: tb/tb_mram_burst_seq.sv
// tb_mram_burst_seq: directed and random stimulus against a queue-based model of the burst sequencer
module tb_mram_burst_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [15:0] q[$];
  bit tail = 0, m_done = 0, m_abt = 0;
  always #5 clk = ~clk;
  mram_burst_seq_if #(.ADDR_W(16), .LEN_W(8)) bus ();
  mram_burst_seq #(.ADDR_W(16), .LEN_W(8), .WRAP_LOG2(2)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic void model_step();
    int n;
    logic [15:0] a;
    m_done = 0;
    m_abt = 0;
    if (q.size() > 0) begin
      if (bus.abort) begin
        q.delete();
        m_abt = 1;
      end else if (bus.addr_ready) begin
        void'(q.pop_front());
        if (q.size() == 0) begin
          m_done = 1;
          tail = 1;
        end
      end
    end else if (tail) tail = 0;
    else if (bus.start) begin
      n = bus.mode_sel ? ((bus.burst_len == 0) ? 1 : int'(bus.burst_len)) : 1;
      for (int i = 0; i < n; i++) begin
        a = bus.start_addr + 16'(i);
        if (bus.mode_sel && bus.burst_type) a = (bus.start_addr & 16'hFFFC) | (a & 16'h0003);
        q.push_back(a);
      end
    end
  endfunction
  task automatic compare();
    chk("valid", bus.addr_valid, q.size() > 0);
    if (q.size() > 0) chk("addr", bus.addr_out, q[0]);
    chk("last", bus.last, q.size() == 1);
    chk("beats_left", bus.beats_left, q.size());
    chk("busy", bus.busy, q.size() > 0 || tail);
    chk("done", bus.done, m_done);
    chk("aborted", bus.aborted, m_abt);
  endtask
  task automatic cyc(input logic st, md, bt, input logic [15:0] a, input logic [7:0] l, input logic ab, rd);
    bus.start = st;
    bus.mode_sel = md;
    bus.burst_type = bt;
    bus.start_addr = a;
    bus.burst_len = l;
    bus.abort = ab;
    bus.addr_ready = rd;
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 16'h0, 8'h0, 0, 1);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_addr"}, bus.addr_out, 0);
    chk({tag, "_valid"}, bus.addr_valid, 0);
    chk({tag, "_last"}, bus.last, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_aborted"}, bus.aborted, 0);
    chk({tag, "_left"}, bus.beats_left, 0);
  endtask
  initial begin
    bus.start = 0; bus.mode_sel = 0; bus.burst_type = 0; bus.start_addr = 0;
    bus.burst_len = 0; bus.abort = 0; bus.addr_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    @(negedge clk);
    rst = 0;
    idle(2);
    // single transfer ignores burst_len
    cyc(1, 0, 1, 16'h1234, 8'd9, 0, 1);
    chk("single_addr", bus.addr_out, 16'h1234);
    chk("single_last", bus.last, 1);
    idle(4);
    // INCR across the top of the address space with stalls
    cyc(1, 1, 0, 16'hFFFE, 8'd4, 0, 0);
    cyc(0, 0, 0, 16'h0, 8'd0, 0, 1);
    chk("incr_2nd", bus.addr_out, 16'hFFFF);
    cyc(0, 0, 0, 16'h0, 8'd0, 0, 0);
    cyc(0, 0, 0, 16'h0, 8'd0, 0, 0);
    cyc(0, 0, 0, 16'h0, 8'd0, 0, 1);
    chk("incr_wrap0", bus.addr_out, 16'h0000);
    cyc(0, 0, 0, 16'h0, 8'd0, 0, 1);
    chk("incr_last", bus.last, 1);
    cyc(0, 0, 0, 16'h0, 8'd0, 0, 1);
    idle(3);
    // WRAP within a 4-beat window, burst longer than the window
    cyc(1, 1, 1, 16'h0106, 8'd6, 0, 1);
    cyc(0, 0, 0, 16'h0, 8'd0, 0, 1);
    cyc(0, 0, 0, 16'h0, 8'd0, 0, 1);
    chk("wrap_3rd", bus.addr_out, 16'h0104);
    idle(6);
    // zero length in burst mode means one beat
    cyc(1, 1, 0, 16'h0ABC, 8'd0, 0, 1);
    chk("len0_last", bus.last, 1);
    idle(3);
    // abort on the third beat together with ready, then immediate restart
    cyc(1, 1, 0, 16'h2000, 8'd8, 0, 1);
    cyc(0, 0, 0, 16'h0, 8'd0, 0, 1);
    cyc(0, 0, 0, 16'h0, 8'd0, 0, 1);
    cyc(0, 0, 0, 16'h0, 8'd0, 1, 1);
    chk("abort_pulse", bus.aborted, 1);
    cyc(1, 1, 0, 16'h3000, 8'd2, 0, 1);
    chk("restart_addr", bus.addr_out, 16'h3000);
    // start while busy and in the DONE cycle is dropped
    cyc(1, 1, 0, 16'h4000, 8'd3, 0, 1);
    cyc(1, 1, 0, 16'h4000, 8'd3, 0, 1);
    chk("done_pulse", bus.done, 1);
    cyc(1, 1, 0, 16'h5000, 8'd3, 0, 1);
    chk("ignored_start", bus.busy, 0);
    idle(2);
    // asynchronous reset mid-burst
    cyc(1, 1, 0, 16'h6000, 8'd10, 0, 1);
    cyc(0, 0, 0, 16'h0, 8'd0, 0, 1);
    rst = 1;
    #1;
    chk_reset("async_rst");
    q.delete();
    tail = 0;
    @(negedge clk);
    rst = 0;
    idle(2);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [15:0] a;
      a = $urandom_range(0, 1) ? 16'(16'hFFF8 + $urandom_range(0, 7)) : 16'($urandom);
      cyc($urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom), a, 8'($urandom_range(0, 10)),
          $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
    end
    idle(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
